// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the tdm_mux block: FSM state encoding and the
// next-unmasked-channel search used by the TDM_MUX_MASK_EN build.
package tdm_mux_pkg;

   typedef enum logic {
      MANUAL = 1'b0,
      SCAN   = 1'b1
   } state_t;

   // Upper bound on CHANNELS for the mask search; masks are passed widened.
   localparam int MAX_CHANNELS = 64;

   // Returns the first unmasked index at or after start (wrapping at channels).
   // Returns start when every channel is masked; callers gate on that case.
   function automatic int next_unmasked(input logic [MAX_CHANNELS-1:0] mask,
                                        input int start,
                                        input int channels);
      int   idx;
      int   result;
      logic found;
      result = start;
      found  = 1'b0;
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         if (!found && i < channels) begin
            idx = start + i;
            if (idx >= channels) idx = idx - channels;
            if (!mask[idx]) begin
               found  = 1'b1;
               result = idx;
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/tdm_mux_if.sv
// Bus bundle for tdm_mux: parallel channel inputs, select/mode controls and
// the registered output stream. Optional ch_mask under TDM_MUX_MASK_EN.
interface tdm_mux_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      mode;
   logic [SEL_W-1:0]          sel_in;
   logic                      enable;
`ifdef TDM_MUX_MASK_EN
   logic [CHANNELS-1:0]       ch_mask;
`endif
   // out_valid qualifies out_data/out_ch for that single cycle only; there is
   // no ready/backpressure, so the consumer must take the sample when valid.
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_ch;
   logic                      out_valid;
   logic                      wrap;

   modport master (
`ifdef TDM_MUX_MASK_EN
      output ch_mask,
`endif
      output in_data, mode, sel_in, enable,
      input  out_data, out_ch, out_valid, wrap
   );

   modport slave (
`ifdef TDM_MUX_MASK_EN
      input  ch_mask,
`endif
      input  in_data, mode, sel_in, enable,
      output out_data, out_ch, out_valid, wrap
   );

endinterface

// File: rtl/tdm_mux_scan_ctr.sv
// Scan pointer and dwell counter for tdm_mux, with wrap detection.
// Build option TDM_MUX_MASK_EN adds a channel-skip mask to the pointer advance.
module tdm_scan_ctr #(
   parameter int CHANNELS = 4,
   parameter int DWELL    = 1,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
`ifdef TDM_MUX_MASK_EN
   input  logic [CHANNELS-1:0] mask,
`endif
   output logic [SEL_W-1:0] cur_ptr,
   output logic             cur_ok,
   output logic             wrap_hit
);
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0] ptr_q, ptr_d, base_ptr, step_ptr;
   logic [DW_W-1:0]  dwell_q, dwell_d, base_dwell;
   logic             at_end, last_dwell;

   // On the entry edge the loaded values are used directly, so channel 0 (or
   // the lowest unmasked channel) is presented on that same edge.
`ifdef TDM_MUX_MASK_EN
   logic [tdm_mux_pkg::MAX_CHANNELS-1:0] mask_ext;

   always_comb begin
      mask_ext                 = '1;
      mask_ext[CHANNELS-1:0]   = mask;
   end

   assign base_ptr = load ? SEL_W'(tdm_mux_pkg::next_unmasked(mask_ext, 0, CHANNELS)) : ptr_q;
   assign cur_ok   = ~mask[base_ptr];
   assign step_ptr = SEL_W'(tdm_mux_pkg::next_unmasked(mask_ext, int'(base_ptr) + 1, CHANNELS));
   // Landing at or below the current index means the search passed CHANNELS-1.
   assign at_end   = (step_ptr <= base_ptr);
`else
   assign base_ptr = load ? '0 : ptr_q;
   assign cur_ok   = 1'b1;
   assign at_end   = (base_ptr == CH_LAST);
   assign step_ptr = at_end ? '0 : base_ptr + 1'b1;
`endif

   assign base_dwell = load ? '0 : dwell_q;
   assign last_dwell = (base_dwell == DWELL_LAST);
   assign cur_ptr    = base_ptr;
   assign wrap_hit   = enable && cur_ok && last_dwell && at_end;

   always_comb begin
      ptr_d   = base_ptr;
      dwell_d = base_dwell;
      if (enable && cur_ok) begin
         if (last_dwell) begin
            dwell_d = '0;
            ptr_d   = step_ptr;
         end else begin
            dwell_d = base_dwell + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= '0;
         dwell_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         dwell_q <= dwell_d;
      end
   end

endmodule

// File: rtl/tdm_mux.sv
// N:1 registered TDM multiplexer with manual select and auto-scan modes.
// Build option TDM_MUX_MASK_EN adds bus.ch_mask to skip channels.
module tdm_mux
   import tdm_mux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 1
) (
   input  logic     clk,
   input  logic     reset,
   tdm_mux_if.slave bus,
   output state_t   dbg_state
);
   localparam int SEL_W = $clog2(CHANNELS);
   localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

   state_t           state_q, state_d;
   logic             load;
   logic             scan_en;
   logic [SEL_W-1:0] cur_ptr;
   logic             cur_ok;
   logic             wrap_hit;
   logic             sel_ok;
   logic [SEL_W-1:0] mux_idx;
   logic [WIDTH-1:0] picked;

   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;

   assign scan_en = bus.mode & bus.enable;
   assign load    = (state_q == MANUAL) & bus.mode;

   tdm_scan_ctr #(
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL),
      .SEL_W    (SEL_W)
   ) u_scan_ctr (
      .clk      (clk),
      .reset    (reset),
      .enable   (scan_en),
      .load     (load),
`ifdef TDM_MUX_MASK_EN
      .mask     (bus.ch_mask),
`endif
      .cur_ptr  (cur_ptr),
      .cur_ok   (cur_ok),
      .wrap_hit (wrap_hit)
   );

`ifdef TDM_MUX_MASK_EN
   assign sel_ok = (bus.sel_in <= CH_LAST) && !bus.ch_mask[bus.sel_in];
`else
   assign sel_ok = (bus.sel_in <= CH_LAST);
`endif

   // Mode, not state, picks the source: leaving SCAN uses sel_in on that edge.
   assign mux_idx = bus.mode ? cur_ptr : bus.sel_in;

   always_comb begin
      picked = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (mux_idx == SEL_W'(k)) picked = bus.in_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      case (state_q)
         MANUAL:  if (bus.mode)  state_d = SCAN;
         SCAN:    if (!bus.mode) state_d = MANUAL;
         default: state_d = MANUAL;
      endcase
      if (bus.enable) begin
         if (bus.mode) begin
            if (cur_ok) begin
               data_d  = picked;
               ch_d    = cur_ptr;
               valid_d = 1'b1;
               wrap_d  = wrap_hit;
            end
         end else begin
            ch_d = bus.sel_in;
            if (sel_ok) begin
               data_d  = picked;
               valid_d = 1'b1;
            end else begin
               data_d  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MANUAL;
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_ch    = ch_q;
   assign bus.out_valid = valid_q;
   assign bus.wrap      = wrap_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux: two instances (4ch/dwell 1 and 3ch/dwell 3), an
// enabled-cycle-count reference model, and directed literal expectations.
module tb_tdm_mux;
   import tdm_mux_pkg::*;

   typedef struct {
      int         k;
      bit         in_scan;
      logic [7:0] data;
      int         ch;
      bit         valid;
      bit         wrap;
   } mdl_t;

   logic   clk;
   logic   reset_a, reset_b;
   state_t state_a, state_b;
   logic [3:0] mask_a, mask_b;
   int     n_checks, n_errors;
   bit     cmp_on;
   mdl_t   m_a, m_b;
   logic [7:0] exp_q[$];
   logic [7:0] exp_wrap_q[$];

   tdm_mux_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
   tdm_mux_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

   tdm_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) dut_a (
      .clk(clk), .reset(reset_a), .bus(bus_a), .dbg_state(state_a));
   tdm_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) dut_b (
      .clk(clk), .reset(reset_b), .bus(bus_b), .dbg_state(state_b));

`ifdef TDM_MUX_MASK_EN
   assign bus_a.ch_mask = mask_a;
   assign bus_b.ch_mask = mask_b[2:0];
`endif

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: in scan, the k-th enabled cycle since entry shows entry
   // (k / dwell) mod N of the unmasked-channel list; wrap on the last slot.
   function automatic mdl_t model_next(input mdl_t m, input bit rst, input bit mode,
                                       input bit en, input int sel, input logic [31:0] din,
                                       input int chans, input int dwell, input logic [3:0] mask);
      mdl_t n;
      int   lst[$];
      int   p;
      n       = m;
      n.valid = 1'b0;
      n.wrap  = 1'b0;
      if (rst) begin
         n.k = 0; n.in_scan = 1'b0; n.data = 8'h00; n.ch = 0;
         return n;
      end
      if (mode) begin
         if (!n.in_scan) begin
            n.in_scan = 1'b1;
            n.k       = 0;
         end
         if (en) begin
            for (int c = 0; c < chans; c++) if (!mask[c]) lst.push_back(c);
            if (lst.size() > 0) begin
               p       = (n.k / dwell) % lst.size();
               n.ch    = lst[p];
               n.data  = din[lst[p]*8 +: 8];
               n.valid = 1'b1;
               n.wrap  = ((n.k % dwell) == dwell - 1) && (p == lst.size() - 1);
               n.k     = n.k + 1;
            end
         end
      end else begin
         n.in_scan = 1'b0;
         if (en) begin
            n.ch = sel;
            if (sel < chans && !mask[sel]) begin
               n.data  = din[sel*8 +: 8];
               n.valid = 1'b1;
            end else begin
               n.data = 8'h00;
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m_a = model_next(m_a, reset_a, bus_a.mode, bus_a.enable, int'(bus_a.sel_in),
                       bus_a.in_data, 4, 1, mask_a);
      m_b = model_next(m_b, reset_b, bus_b.mode, bus_b.enable, int'(bus_b.sel_in),
                       {8'h00, bus_b.in_data}, 3, 3, mask_b);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process: every cycle, both instances against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         check("a_data",  bus_a.out_data,  m_a.data);
         check("a_ch",    bus_a.out_ch,    m_a.ch);
         check("a_valid", bus_a.out_valid, m_a.valid);
         check("a_wrap",  bus_a.wrap,      m_a.wrap);
         check("a_state", state_a == SCAN, m_a.in_scan);
         check("b_data",  bus_b.out_data,  m_b.data);
         check("b_ch",    bus_b.out_ch,    m_b.ch);
         check("b_valid", bus_b.out_valid, m_b.valid);
         check("b_wrap",  bus_b.wrap,      m_b.wrap);
         check("b_state", state_b == SCAN, m_b.in_scan);
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input bit mode, input bit en, input int sel);
      bus_a.mode = mode; bus_a.enable = en; bus_a.sel_in = 2'(sel);
   endtask

   task automatic drive_b(input bit mode, input bit en, input int sel);
      bus_b.mode = mode; bus_b.enable = en; bus_b.sel_in = 2'(sel);
   endtask

   // scoreboard: run n ticks popping expected out_ch / wrap literals
   task automatic run_seq(input string name, input bit use_a, input int n);
      logic [7:0] e_ch, e_wr;
      for (int i = 0; i < n; i++) begin
         tick();
         e_ch = exp_q.pop_front();
         e_wr = exp_wrap_q.pop_front();
         if (use_a) begin
            check({name, "_ch"},   bus_a.out_ch, e_ch);
            check({name, "_wrap"}, bus_a.wrap,   e_wr);
         end else begin
            check({name, "_ch"},   bus_b.out_ch, e_ch);
            check({name, "_wrap"}, bus_b.wrap,   e_wr);
         end
      end
   endtask

   initial begin
      logic [7:0] tbl_a [4];
      int seq2_ch [9];
      int seq2_wr [9];
      int seq3_ch [10];
      tbl_a   = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
      seq2_ch = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      seq2_wr = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
      seq3_ch = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
      n_checks = 0; n_errors = 0; cmp_on = 1'b0;
      m_a = '{k: 0, in_scan: 1'b0, data: 8'h00, ch: 0, valid: 1'b0, wrap: 1'b0};
      m_b = m_a;
      mask_a = 4'b0000; mask_b = 4'b0000;
      reset_a = 1'b1; reset_b = 1'b1;
      bus_a.in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      bus_b.in_data = {8'h33, 8'h22, 8'h11};
      drive_a(0, 0, 0);
      drive_b(0, 0, 0);

      // 1: reset then manual select
      tick();
      cmp_on = 1'b1;
      tick();
      check("rst_data",  bus_a.out_data, 0);
      check("rst_ch",    bus_a.out_ch, 0);
      check("rst_valid", bus_a.out_valid, 0);
      check("rst_wrap",  bus_a.wrap, 0);
      check("rst_state", state_a, MANUAL);
      reset_a = 1'b0;
      drive_a(0, 1, 2);
      tick();
      check("man_data",  bus_a.out_data, 8'hC2);
      check("man_ch",    bus_a.out_ch, 2);
      check("man_valid", bus_a.out_valid, 1);
      for (int s = 0; s < 4; s++) begin
         drive_a(0, 1, s);
         tick();
         check("sweep_data", bus_a.out_data, tbl_a[s]);
      end

      // 2: scan, dwell 1
      drive_a(1, 1, 0);
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(8'(seq2_ch[i]));
         exp_wrap_q.push_back(8'(seq2_wr[i]));
      end
      run_seq("scan4", 1'b1, 9);

      // 5b: reset at pointer 3
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(8'(i));
         exp_wrap_q.push_back(8'(i == 3));
      end
      run_seq("pre_rst", 1'b1, 3);
      reset_a = 1'b1;
      tick();
      check("mid_rst_data",  bus_a.out_data, 0);
      check("mid_rst_ch",    bus_a.out_ch, 0);
      check("mid_rst_valid", bus_a.out_valid, 0);
      check("mid_rst_state", state_a, MANUAL);
      reset_a = 1'b0;
      drive_a(0, 0, 0);

      // 3: scan, 3 channels, dwell 3
      reset_b = 1'b0;
      drive_b(1, 1, 0);
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(8'(seq3_ch[i]));
         exp_wrap_q.push_back(8'(i == 8));
      end
      run_seq("scan3", 1'b0, 10);

      // 4: enable gating mid-dwell
      drive_b(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("gate_valid", bus_b.out_valid, 0);
         check("gate_ch",    bus_b.out_ch, 0);
      end
      drive_b(1, 1, 0);
      exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
      exp_q.push_back(8'd1); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
      repeat (6) exp_wrap_q.push_back(8'd0);
      run_seq("resume", 1'b0, 6);

      // 5: leave scan at pointer 2 mid-dwell, then re-enter
      drive_b(0, 1, 1);
      tick();
      check("sw_man_ch",   bus_b.out_ch, 1);
      check("sw_man_data", bus_b.out_data, 8'h22);
      drive_b(1, 1, 1);
      tick();
      check("reentry_ch",   bus_b.out_ch, 0);
      check("reentry_data", bus_b.out_data, 8'h11);

      // 6: out-of-range select on 3-channel instance
      drive_b(0, 1, 3);
      tick();
      check("bad_sel_valid", bus_b.out_valid, 0);
      check("bad_sel_data",  bus_b.out_data, 0);
      check("bad_sel_ch",    bus_b.out_ch, 3);

`ifdef TDM_MUX_MASK_EN
      mask_a = 4'b0101;
      drive_a(0, 1, 2);
      tick();
      check("mask_man_valid", bus_a.out_valid, 0);
      drive_a(1, 1, 0);
      exp_q.push_back(8'd1); exp_q.push_back(8'd3); exp_q.push_back(8'd1); exp_q.push_back(8'd3);
      exp_wrap_q.push_back(8'd0); exp_wrap_q.push_back(8'd1);
      exp_wrap_q.push_back(8'd0); exp_wrap_q.push_back(8'd1);
      run_seq("mask_scan", 1'b1, 4);
      drive_a(0, 0, 0);
      tick();
      mask_a = 4'b1111;
      drive_a(1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("all_mask_valid", bus_a.out_valid, 0);
      end
      drive_a(0, 0, 0);
      mask_a = 4'b0000;
`endif

      tick();
      tick();
      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
